pipelined_function_unit: RTL

Parametrised, registered successor to the CPU's combinational function unit. Executes ALU, shift, compare and iterative multiply/divide operations on WIDTH-bit operands. Uses a valid/ready handshake on both sides: single-cycle ops return one cycle after acceptance, and multiply/divide ops iterate over WIDTH cycles. Sits between the register-read stage and writeback, and can stall the pipeline while busy.

---
 rtl/pipelined_function_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_function_unit.sv
// Registered ALU/shift/compare unit with an iterative shift-add multiplier and restoring divider.
// Valid/ready handshake on both sides; single-cycle ops return in one cycle, mul/div in WIDTH+1.
module pipelined_function_unit #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_op_mul;
  logic             r_op_hi;

  logic             w_accept;
  logic             w_is_iter;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH:0]   w_step_add;
  logic [WIDTH:0]   w_step_sh;
  logic [WIDTH:0]   w_step_sub;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_iter_res;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_iter = MULDIV_EN && (FS >= 4'd10) && (FS <= 4'd13);
  assign w_sum     = {1'b0, A} + {1'b0, B};
  assign w_diff    = {1'b0, A} - {1'b0, B};

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign Result    = r_result;
  assign Z         = r_z;
  assign C         = r_c;
  assign V         = r_v;

  // Single-cycle datapath evaluated on the live operands
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (FS)
      4'd0: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = ~w_diff[WIDTH];
        w_alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2:    w_alu_res = A & B;
      4'd3:    w_alu_res = A | B;
      4'd4:    w_alu_res = A ^ B;
      4'd5:    w_alu_res = A << B[SHW-1:0];
      4'd6:    w_alu_res = A >> B[SHW-1:0];
      4'd7:    w_alu_res = $signed(A) >>> B[SHW-1:0];
      4'd8:    w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd9:    w_alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
  end

  // One multiply (shift-add) or divide (restoring) step; acc holds high product / remainder
  always_comb begin
    w_step_add = {1'b0, r_acc} + {1'b0, r_m};
    w_step_sh  = {r_acc, r_q[WIDTH-1]};
    w_step_sub = w_step_sh - {1'b0, r_m};
    w_acc_nxt  = r_acc;
    w_q_nxt    = r_q;
    if (r_op_mul) begin
      if (r_q[0]) begin
        {w_acc_nxt, w_q_nxt} = {w_step_add, r_q[WIDTH-1:1]};
      end else begin
        {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[WIDTH-1:1]};
      end
    end else if (!w_step_sub[WIDTH]) begin
      w_acc_nxt = w_step_sub[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = w_step_sh[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
    end
    w_iter_res = r_op_hi ? w_acc_nxt : w_q_nxt;
  end

  // Control FSM, operand capture and registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_cnt       <= {SHW{1'b0}};
      r_acc       <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      r_m         <= {WIDTH{1'b0}};
      r_op_mul    <= 1'b0;
      r_op_hi     <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= {SHW{1'b0}};
    end else begin
      case (r_state)
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          if (r_cnt == {SHW{1'b0}}) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_result    <= w_iter_res;
            r_z         <= (w_iter_res == {WIDTH{1'b0}});
            r_c         <= 1'b0;
            r_v         <= 1'b0;
          end else begin
            r_cnt <= r_cnt - {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        S_IDLE, S_DONE: begin
          if (w_accept && w_is_iter) begin
            // FS[2] clear selects MUL/MULHU, set selects DIVU/REMU; FS[0] picks the high half
            r_state     <= S_BUSY;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= SHW'(WIDTH - 1);
            r_op_mul    <= ~FS[2];
            r_op_hi     <= FS[0];
            r_m         <= FS[2] ? B : A;
            r_q         <= FS[2] ? A : B;
            r_acc       <= {WIDTH{1'b0}};
          end else if (w_accept) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_z         <= (w_alu_res == {WIDTH{1'b0}});
            r_c         <= w_alu_c;
            r_v         <= w_alu_v;
          end else if ((r_state == S_DONE) && !out_ready) begin
            r_state <= S_DONE;
          end else begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
